// File: rtl/edge_pkg.sv
// ============================================================================
//  Module      : edge_pkg
//  Description : Shared image geometry constants and types for the
//                edge-detection front end (line_window_feed and line_ram).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_pkg;

  localparam int IMG_WIDTH  = 720;
  localparam int IMG_HEIGHT = 540;
  localparam int PIXEL_W    = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/line_ram.sv
// ============================================================================
//  Module      : line_ram
//  Description : One image row of pixel storage. Writes land on the clock
//                edge while the read port shows the current contents, so a
//                consumer registering rdata_o on the same edge as a write
//                captures the previous value (read-before-write).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_ram #(
  parameter int DEPTH = edge_pkg::IMG_WIDTH,
  parameter int WIDTH = edge_pkg::PIXEL_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Row storage write; contents need no reset since unread rows are masked.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_window_feed.sv
// ============================================================================
//  Module      : line_window_feed
//  Description : Raster pixel stream in, vertical 3-pixel columns out.
//                Two line buffers hold the previous rows; rows above the
//                image are zero-filled. Single registered output stage.
//                Optional macro EDGE_REPLICATE_EN: replicate the top edge
//                instead of zero-filling.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_window_feed #(
  parameter int IMG_WIDTH  = edge_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = edge_pkg::IMG_HEIGHT,
  parameter int PIXEL_W    = edge_pkg::PIXEL_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sof,
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] col_top,
  output logic [PIXEL_W-1:0] col_mid,
  output logic [PIXEL_W-1:0] col_bot,
  output logic               window_valid,
  output logic               frame_done
);

  import edge_pkg::*;

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  fill_state_t        state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [PIXEL_W-1:0] col_top_q, col_top_d;
  logic [PIXEL_W-1:0] col_mid_q, col_mid_d;
  logic [PIXEL_W-1:0] col_bot_q, col_bot_d;
  logic               out_valid_q, out_valid_d;
  logic               window_valid_q, window_valid_d;
  logic               last_q, last_d;
  logic               frame_done_q, frame_done_d;

  logic               accept;
  logic               transfer;
  logic               process;
  logic [XW-1:0]      x_eff;
  logic [YW-1:0]      y_eff;
  logic [PIXEL_W-1:0] row1_rd;
  logic [PIXEL_W-1:0] row2_rd;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_q && out_ready;
  // Outside a frame only a sof beat produces a column; other beats are eaten.
  assign process  = accept && (sof || (state_q != S_IDLE));
  // A sof beat is always pixel (0,0), which also resyncs a frame in progress.
  assign x_eff    = sof ? '0 : x_q;
  assign y_eff    = sof ? '0 : y_q;

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W), .AW(XW)) u_row1 (
    .clock   (clock),
    .we_i    (process),
    .addr_i  (x_eff),
    .wdata_i (in_data),
    .rdata_o (row1_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W), .AW(XW)) u_row2 (
    .clock   (clock),
    .we_i    (process),
    .addr_i  (x_eff),
    .wdata_i (row1_rd),
    .rdata_o (row2_rd)
  );

  // Next-state: column build, raster counters, fill/run tracking, handshake.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    col_top_d      = col_top_q;
    col_mid_d      = col_mid_q;
    col_bot_d      = col_bot_q;
    window_valid_d = window_valid_q;
    last_d         = last_q;
    out_valid_d    = out_valid_q;
    frame_done_d   = transfer && last_q;

    if (process) begin
      col_bot_d = in_data;
`ifdef EDGE_REPLICATE_EN
      if (y_eff == '0) begin
        col_top_d = in_data;
        col_mid_d = in_data;
      end else if (y_eff == YW'(1)) begin
        col_top_d = row1_rd;
        col_mid_d = row1_rd;
      end else begin
        col_top_d = row2_rd;
        col_mid_d = row1_rd;
      end
      window_valid_d = (y_eff != '0) && (x_eff >= XW'(2));
`else
      col_mid_d      = (y_eff == '0) ? '0 : row1_rd;
      col_top_d      = (y_eff >= YW'(2)) ? row2_rd : '0;
      window_valid_d = (y_eff >= YW'(2)) && (x_eff >= XW'(2));
`endif
      last_d      = (x_eff == X_LAST) && (y_eff == Y_LAST);
      out_valid_d = 1'b1;

      if (x_eff == X_LAST) begin
        x_d = '0;
        if (y_eff == Y_LAST) begin
          y_d     = '0;
          state_d = S_IDLE;
        end else begin
          y_d     = y_eff + YW'(1);
          state_d = ((y_eff + YW'(1)) >= YW'(2)) ? S_RUN : S_FILL;
        end
      end else begin
        x_d     = x_eff + XW'(1);
        y_d     = y_eff;
        state_d = (y_eff >= YW'(2)) ? S_RUN : S_FILL;
      end
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output-stage registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      col_top_q      <= '0;
      col_mid_q      <= '0;
      col_bot_q      <= '0;
      window_valid_q <= 1'b0;
      last_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      col_top_q      <= col_top_d;
      col_mid_q      <= col_mid_d;
      col_bot_q      <= col_bot_d;
      window_valid_q <= window_valid_d;
      last_q         <= last_d;
      out_valid_q    <= out_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign col_top      = col_top_q;
  assign col_mid      = col_mid_q;
  assign col_bot      = col_bot_q;
  assign window_valid = window_valid_q;
  assign frame_done   = frame_done_q;

endmodule

`default_nettype wire

// File: doc/line_window_feed.md
Name: line_window_feed

Overview:
- Upstream neighbour of the 3-pixel shift registers in the edge-detection datapath.
- Accepts a raster-order grayscale pixel stream, one pixel per handshake.
- Stores the two previous image rows in line buffers.
- Emits one vertical 3-pixel column (top/mid/bottom) per accepted pixel. Three downstream shift_reg_3 instances consume the columns to build the 3x3 Sobel window.

Parameters:
- IMG_WIDTH, 720, pixels per row (>=3)
- IMG_HEIGHT, 540, rows per frame (>=3)
- PIXEL_W, 8, bits per pixel

Ports:
- clock  input  1  single clock for all logic
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- sof  input  1  start-of-frame; qualifies the in_data beat carrying pixel (0,0)
- in_valid  input  1  upstream pixel valid
- in_data  input  PIXEL_W  upstream pixel
- in_ready  output  1  block can accept a pixel this cycle
- out_valid  output  1  column registers hold a valid column
- out_ready  input  1  downstream accepts column; downstream drives shift_en from out_valid & out_ready
- col_top  output  PIXEL_W  pixel at (x, y-2)
- col_mid  output  PIXEL_W  pixel at (x, y-1)
- col_bot  output  PIXEL_W  pixel at (x, y)
- window_valid  output  1  qualifies column: 3x3 window ending at this column is fully inside the image
- frame_done  output  1  one-cycle pulse after the last column of a frame transfers

Behaviour:
- Reset (reset==0, async): out_valid=0, window_valid=0, frame_done=0, col_*=0, x=y=0, FSM=S_IDLE. Line-buffer contents are don't-care.
- Handshakes:
  - in_ready = !out_valid | out_ready (single output stage, no bubble).
  - Input accepted when in_valid & in_ready.
  - Output transfers when out_valid & out_ready. Columns hold stable while out_valid & !out_ready.
- Latency: exactly 1 cycle. A pixel accepted on cycle N has its column on the outputs at N+1 with out_valid=1.
- Accept at column x, row y:
  - col_bot <= in_data; col_mid <= row1[x]; col_top <= row2[x].
  - Same edge: row2[x] <= row1[x] and row1[x] <= in_data (read-before-write).
- Counters x in 0..IMG_WIDTH-1, y in 0..IMG_HEIGHT-1, advanced per accept.
  - x wraps to 0 and increments y.
  - At x=IMG_WIDTH-1, y=IMG_HEIGHT-1, both wrap to 0.
- FSM:
  - S_IDLE: accept only on sof=1; beats with sof=0 are accepted and dropped (no column). Move to S_FILL on the sof beat.
  - S_FILL (y<2): upper rows are zero-filled. y==0 gives top=mid=0; y==1 gives top=0.
  - S_RUN (y>=2): all rows taken from line buffers.
  - Returns to S_IDLE after the last pixel of the frame is accepted.
- window_valid registered with the column: 1 iff y>=2 and x>=2 for that pixel.
- frame_done: 1-cycle pulse on the cycle after the last column (x=W-1, y=H-1) transfers.
- sof during S_FILL/S_RUN: frame restarts. That beat is treated as (0,0), counters resync, FSM goes to S_FILL. Stale line-buffer data is masked by zero-fill.
- Simultaneous accept and transfer in one cycle: new column replaces old, out_valid stays 1.
- Reset mid-frame: everything returns to reset values; the next frame requires sof.

Optional Feature:
- Macro EDGE_REPLICATE_EN.
- Defined: S_FILL replicates instead of zero-filling.
  - y==0: top=mid=bot=in_data.
  - y==1: top=mid=row1[x].
  - window_valid becomes x>=2 for all y>=1.
- Undefined: zero-fill as above.

Decomposition:
- Package edge_pkg:
  - IMG_WIDTH, IMG_HEIGHT, PIXEL_W constants
  - pixel_t typedef
  - column_t typedef (struct top/mid/bot)
  - fill_state_t enum (S_IDLE, S_FILL, S_RUN)
- Sub-module line_ram: IMG_WIDTH x PIXEL_W, synchronous read-before-write, address x. Instantiated twice (row1, row2).

Test Plan:
- Reset then sof with pixel 0x11, out_ready=1 -> next cycle out_valid=1, col={0,0,0x11}, window_valid=0.
- 5x4 image with pixel value = 10*y+x, continuous -> column at (3,2) = {03,13,23}, window_valid=1. window_valid count = 3*2 = 6.
- out_ready held 0 for 4 cycles mid-row -> in_ready=0, columns stable, no pixel lost. Resumed stream matches golden.
- sof reasserted at (2,1) -> counters reset, next column top=mid=0. frame_done not pulsed for the aborted frame.
- Last pixel (W-1,H-1) transfers -> frame_done=1 for exactly one cycle. Beats with sof=0 afterwards are dropped.
- EDGE_REPLICATE_EN defined, row 0 pixel 0x40 -> col={0x40,0x40,0x40}.
